// File: rtl/reg_req_bridge.sv
// Request/response bridge to the register block; one transaction in flight, latency wr=2 rd=3 err=1 cycles from accept.
// Backpressure: req_ready only in IDLE; a withheld rsp_ready holds the response indefinitely.
module reg_req_bridge #(
    parameter int         DWIDTH   = 8,
    parameter int         AWIDTH   = 8,
    parameter int         NUM_REGS = 2,
    parameter logic [1:0] OP_NOP   = 2'b00,
    parameter logic [1:0] OP_RD    = 2'b01,
    parameter logic [1:0] OP_WR    = 2'b10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        reg_op,
    output logic [AWIDTH-1:0] reg_addr,
    output logic [DWIDTH-1:0] reg_wdata,
    input  logic [DWIDTH-1:0] reg_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RSP} state_t;

    // One extra bit so NUM_REGS == 2**AWIDTH still compares correctly.
    localparam logic [AWIDTH:0] NUM_REGS_W = (AWIDTH+1)'(NUM_REGS);

    state_t              state_q, state_d;
    logic                wr_q;
    logic [1:0]          reg_op_q;
    logic [AWIDTH-1:0]   reg_addr_q;
    logic [DWIDTH-1:0]   reg_wdata_q;
    logic                rsp_write_q;
    logic                rsp_err_q;
    logic [DWIDTH-1:0]   rsp_rdata_q;

    logic accept;
    logic addr_ok;

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign addr_ok   = {1'b0, req_addr} < NUM_REGS_W;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE:    if (accept) state_d = addr_ok ? ISSUE : RSP;
            ISSUE:   state_d = wr_q ? RSP : WAIT;
            WAIT:    state_d = RSP;
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The strobe is registered at accept so it is high exactly during ISSUE;
    // reg_addr/reg_wdata only move for in-range requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q        <= 1'b0;
            reg_op_q    <= OP_NOP;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            reg_op_q <= OP_NOP;
            if (accept) begin
                wr_q <= req_write;
                if (addr_ok) begin
                    reg_op_q    <= req_write ? OP_WR : OP_RD;
                    reg_addr_q  <= req_addr;
                    reg_wdata_q <= req_wdata;
                end else begin
                    rsp_write_q <= req_write;
                    rsp_err_q   <= 1'b1;
                    rsp_rdata_q <= '0;
                end
            end
            if (state_q == ISSUE && wr_q) begin
                rsp_write_q <= 1'b1;
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= '0;
            end
            if (state_q == WAIT) begin
                rsp_write_q <= 1'b0;
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= reg_rdata;
            end
        end
    end

    assign reg_op    = reg_op_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign rsp_write = rsp_write_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_reg_req_bridge.sv
// Scoreboard bench for reg_req_bridge: driver queues expected responses and strobes,
// a negedge monitor checks them against a small two-register block model.
module tb_reg_req_bridge;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       rsp_write;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [1:0] reg_op;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata = 8'h00;

    reg_req_bridge dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .reg_op(reg_op), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register block: two registers, read data registered one cycle after the strobe.
    logic [7:0] regs [2] = '{8'h00, 8'h00};
    always @(posedge clk) begin
        if (reg_op == OP_WR && reg_addr < 8'd2) regs[reg_addr[0]] <= reg_wdata;
        if (reg_op == OP_RD) reg_rdata <= regs[reg_addr[0]];
    end

    typedef struct { logic wr; logic [7:0] rdata; logic err; int acc; int lat; } rsp_t;
    typedef struct { logic [1:0] op; logic [7:0] addr; logic [7:0] wdata; int cyc; } stb_t;
    rsp_t rsp_q[$];
    stb_t stb_q[$];

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Present a request (req_valid left high on return) and queue what it should produce.
    task automatic send(input logic wr, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, input logic exp_err, input bit exp_rsp);
        int w;
        rsp_t r;
        stb_t s;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", 32'(req_ready), 32'd1);
        if (req_ready) begin
            if (exp_rsp) begin
                r.wr = wr; r.rdata = exp_rd; r.err = exp_err; r.acc = cyc;
                r.lat = exp_err ? 1 : (wr ? 2 : 3);
                rsp_q.push_back(r);
            end
            if (!exp_err) begin
                s.op = wr ? OP_WR : OP_RD; s.addr = a; s.wdata = d; s.cyc = cyc + 1;
                stb_q.push_back(s);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (rsp_q.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        chk("drain_pending", 32'(rsp_q.size()), 32'd0);
    endtask

    // Monitor: strobe checks, response pops on handshake, stability while stalled.
    int   first_cyc = 0;
    logic prev_v = 1'b0;
    logic prev_hs = 1'b0;
    logic snap_w = 1'b0;
    logic snap_e = 1'b0;
    logic [7:0] snap_d = 8'h00;

    always @(negedge clk) begin
        stb_t s;
        rsp_t r;
        if (reg_op != OP_NOP) begin
            if (stb_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL reg_op_unexpected: got op %0d addr 0x%0h expected NOP (cycle %0d)", reg_op, reg_addr, cyc);
            end else begin
                s = stb_q.pop_front();
                chk("reg_op", 32'(reg_op), 32'(s.op));
                chk("reg_addr", 32'(reg_addr), 32'(s.addr));
                chk("reg_wdata", 32'(reg_wdata), 32'(s.wdata));
                chk("reg_op_cycle", 32'(cyc), 32'(s.cyc));
            end
        end
        if (rsp_valid) begin
            if (!prev_v) first_cyc = cyc;
            if (prev_v && !prev_hs) begin
                chk("stall_rsp_write", 32'(rsp_write), 32'(snap_w));
                chk("stall_rsp_rdata", 32'(rsp_rdata), 32'(snap_d));
                chk("stall_rsp_err", 32'(rsp_err), 32'(snap_e));
            end
            snap_w = rsp_write; snap_d = rsp_rdata; snap_e = rsp_err;
            if (rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL rsp_unexpected: got rdata 0x%0h err %0d expected no response (cycle %0d)", rsp_rdata, rsp_err, cyc);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_write", 32'(rsp_write), 32'(r.wr));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
                    chk("rsp_err", 32'(rsp_err), 32'(r.err));
                    chk("rsp_latency", 32'(first_cyc - r.acc), 32'(r.lat));
                end
            end
        end
        prev_v  = rsp_valid;
        prev_hs = rsp_valid && rsp_ready;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_reg_op", 32'(reg_op), 32'(OP_NOP));
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_write", 32'(rsp_write), 32'd0);
        chk("rst_reg_addr", 32'(reg_addr), 32'd0);
        chk("rst_reg_wdata", 32'(reg_wdata), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // Write then read back.
        send(1'b1, 8'h01, 8'h5A, 8'h00, 1'b0, 1'b1);
        send(1'b0, 8'h01, 8'h00, 8'h5A, 1'b0, 1'b1);
        req_valid = 1'b0;
        drain();

        // Out-of-range read and write: error, no strobe.
        send(1'b0, 8'h02, 8'h00, 8'h00, 1'b1, 1'b1);
        send(1'b1, 8'hFF, 8'h77, 8'h00, 1'b1, 1'b1);
        req_valid = 1'b0;
        drain();

        // Response backpressure for 5 cycles.
        rsp_ready = 1'b0;
        send(1'b1, 8'h00, 8'h33, 8'h00, 1'b0, 1'b1);
        req_valid = 1'b0;
        w = 0;
        @(negedge clk);
        while (!rsp_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (5) begin
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("release_req_ready", 32'(req_ready), 32'd1);
        chk("release_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("stall_pending", 32'(rsp_q.size()), 32'd0);

        // Reset during WAIT drops the read.
        send(1'b0, 8'h00, 8'hC3, 8'h00, 1'b0, 1'b0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_reg_op", 32'(reg_op), 32'(OP_NOP));
        chk("midrst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("midrst_rsp_err", 32'(rsp_err), 32'd0);
        chk("midrst_rsp_write", 32'(rsp_write), 32'd0);
        chk("midrst_reg_addr", 32'(reg_addr), 32'd0);
        chk("midrst_reg_wdata", 32'(reg_wdata), 32'd0);
        chk("midrst_req_ready_after", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // Back-to-back with req_valid held high.
        send(1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1);
        send(1'b1, 8'h01, 8'h11, 8'h00, 1'b0, 1'b1);
        send(1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1);
        send(1'b0, 8'h01, 8'h00, 8'h11, 1'b0, 1'b1);
        req_valid = 1'b0;
        drain();

        // Idle window.
        repeat (20) begin
            @(negedge clk);
            chk("idle_reg_op", 32'(reg_op), 32'(OP_NOP));
            chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;

        chk("final_rsp_queue", 32'(rsp_q.size()), 32'd0);
        chk("final_strobe_queue", 32'(stb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
